// File: rtl/mem_arbiter.sv
// Arbiter sharing the unified instruction/data memory between the core datapath
// and an external master, with round-robin ties, external lock and contention counter.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                core_req,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_we,
  output logic                core_gnt,
  output logic                core_rvalid,
  output logic [DATA_W-1:0]   core_rdata,
  input  logic                ext_req,
  input  logic [ADDR_W-1:0]   ext_addr,
  input  logic [DATA_W-1:0]   ext_wdata,
  input  logic [DATA_W/8-1:0] ext_we,
  input  logic                ext_lock,
  output logic                ext_gnt,
  output logic                ext_rvalid,
  output logic [DATA_W-1:0]   ext_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_we,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [CNT_W-1:0]    contention_cnt
);

  localparam logic [1:0] LAST_CORE  = 2'd0;
  localparam logic [1:0] LAST_EXT   = 2'd1;
  localparam logic [1:0] LOCKED_EXT = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic [1:0] arb_state;

  // During reset the grant must already follow the post-reset arbitration.
  assign arb_state = reset ? LAST_EXT : state;

  always_comb begin
    core_gnt = 1'b0;
    ext_gnt  = 1'b0;
    case (arb_state)
      LAST_CORE: begin
        if (ext_req)       ext_gnt  = 1'b1;
        else if (core_req) core_gnt = 1'b1;
      end
      LOCKED_EXT: begin
        ext_gnt = ext_req;
      end
      default: begin
        if (core_req)      core_gnt = 1'b1;
        else if (ext_req)  ext_gnt  = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    if (core_gnt)
      state_next = LAST_CORE;
    else if (ext_gnt)
      state_next = ext_lock ? LOCKED_EXT : LAST_EXT;
    else if (state == LOCKED_EXT && !ext_lock)
      state_next = LAST_EXT;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = '0;
    if (core_gnt) begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_we    = core_we;
    end else if (ext_gnt) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_we    = ext_we;
    end
  end

  // Read data is held per requester until that requester's next granted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= LAST_EXT;
      core_rvalid    <= 1'b0;
      ext_rvalid     <= 1'b0;
      core_rdata     <= '0;
      ext_rdata      <= '0;
      contention_cnt <= '0;
    end else begin
      state       <= state_next;
      core_rvalid <= core_gnt && (core_we == '0);
      ext_rvalid  <= ext_gnt && (ext_we == '0);
      if (core_gnt && (core_we == '0))
        core_rdata <= mem_rdata;
      if (ext_gnt && (ext_we == '0))
        ext_rdata <= mem_rdata;
      if (core_req && ext_req && (contention_cnt != {CNT_W{1'b1}}))
        contention_cnt <= contention_cnt + 1'b1;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single unified instruction/data memory (`MA`) between the core's multicycle datapath and an external port (program loader / debug master). It decides ownership every cycle, steers address, write data and byte-enables onto the memory, and returns registered read data with a valid strobe to the winner. A lock mode lets the external master hold the memory across a multi-word transfer, and a saturating counter records contention for performance debug.

## Interface

- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte enables are `DATA_W/8` bits.
- `CNT_W`, default 16: width of the contention counter.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `core_req`  in  1  core requests an access this cycle.
- `core_addr`  in  ADDR_W  core byte address.
- `core_wdata`  in  DATA_W  core write data.
- `core_we`  in  DATA_W/8  core byte write enables; all zero means read.
- `core_gnt`  out  1  core access performed this cycle.
- `core_rvalid`  out  1  `core_rdata` valid; pulses one cycle after a granted core read.
- `core_rdata`  out  DATA_W  registered read data for the core.
- `ext_req`, `ext_addr`, `ext_wdata`, `ext_we`  in  (same as core)  external-master request.
- `ext_lock`  in  1  external master requests exclusive ownership.
- `ext_gnt`, `ext_rvalid`, `ext_rdata`  out  (same as core)  external-master responses.
- `mem_addr`  out  ADDR_W  to `MA.A`.
- `mem_wdata`  out  DATA_W  to `MA.WD`.
- `mem_we`  out  DATA_W/8  to `MA.WE`.
- `mem_rdata`  in  DATA_W  from `MA.RD`; combinational read of `mem_addr`.
- `contention_cnt`  out  CNT_W  cycles in which both requesters asserted `req`.

## Operation

- Ownership FSM states: `LAST_CORE`, `LAST_EXT`, `LOCKED_EXT`.
  - `LAST_*` stores the most recent winner for round-robin.
  - `LOCKED_EXT`: exclusive external ownership.
- Grant decision is combinational from the current state and the requests:
  - Exactly one requester: it wins, except that in `LOCKED_EXT` the core never wins.
  - Both requesting in `LAST_CORE`: ext wins.
  - Both requesting in `LAST_EXT`: core wins.
  - Both requesting in `LOCKED_EXT`: ext wins.
  - No request: no grant.
- Next state:
  - Core granted: `LAST_CORE`.
  - Ext granted with `ext_lock=1`: `LOCKED_EXT`.
  - Ext granted with `ext_lock=0`: `LAST_EXT`.
  - In `LOCKED_EXT` with `ext_lock=0` and no ext grant: `LAST_EXT`.
  - Otherwise: hold.
- A lock is entered only through a granted ext access. `ext_lock` without `ext_req` has no effect outside `LOCKED_EXT`.
- Memory muxing:
  - `mem_addr`, `mem_wdata`, `mem_we` come from the granted requester.
  - With no grant: `mem_we=0`, and `mem_addr` and `mem_wdata` are 0.
  - At most one requester drives `mem_we` nonzero in any cycle.
- Read return:
  - `x_rvalid <= x_gnt & (x_we==0)`.
  - `x_rdata` captures `mem_rdata` on the same edge and holds until the next granted read by that requester.
  - Writes produce no `rvalid`.
- Contention counter: increments when `core_req & ext_req`. It saturates at all-ones.
- Requesters hold `req`, `addr`, `wdata` and `we` stable until they see `gnt`. Changing the request while ungranted is legal and simply re-arbitrated.

## Timing

- Grant latency: 0 cycles. `gnt` is combinational in the request cycle, and a write commits at the end of that cycle.
- Read latency: 1 cycle. `rvalid` and `rdata` appear in cycle N+1 for a grant in cycle N.
- Back-to-back grants to the same requester are allowed every cycle when the other is idle.
- Under contention, grants strictly alternate one cycle each unless locked.
- Reset (synchronous, dominates all other inputs):
  - State goes to `LAST_EXT`, so the core wins the first tie.
  - `core_rvalid=0`, `ext_rvalid=0`, both `rdata=0`, `contention_cnt=0`.
- Reset asserted mid-lock clears the lock. The grant outputs in the reset cycle follow `LAST_EXT` arbitration, but no state change or rvalid results from that cycle.
- Reset during a granted write cycle: `mem_we` is still driven, and the memory itself is not reset.

## Test plan

- Reset, then core read of 0x10 (mem holds 0xDEADBEEF) → `core_gnt=1` same cycle; next cycle `core_rvalid=1`, `core_rdata=0xDEADBEEF`; `ext_rvalid=0`.
- Both requesters held for 4 cycles from reset → grants core, ext, core, ext; `contention_cnt=4`.
- Ext writes 0x12345678 to 0x20 with `ext_we=4'b1111` while the core idles → `mem_we=4'b1111` in that cycle, no `ext_rvalid`; a core read of 0x20 then returns 0x12345678.
- Ext lock:
  - Ext issues 3 writes with `ext_lock=1` while `core_req=1` throughout → `core_gnt=0` for all 3 cycles.
  - Drop `ext_lock` and `ext_req` → core granted the next cycle.
- Reset asserted during `LOCKED_EXT` with `core_req=1` → after reset the core is granted immediately; `contention_cnt=0`.
- Force `contention_cnt` near saturation with `CNT_W=4` and 20 contended cycles → the counter stops at 15.
